// File: rtl/hit_resolver.sv
// Punch/hit resolution for two fighters: per-fighter attack phase FSM,
// reach check, one-hit-per-attack, counter-hit cancel and knockback decay.
module hit_resolver #(
  parameter logic [7:0]  RYU_PUNCH_KEY   = 8'h09,
  parameter logic [7:0]  AKUMA_PUNCH_KEY = 8'h0E,
  parameter int unsigned STARTUP_CYC     = 3,
  parameter int unsigned ACTIVE_CYC      = 2,
  parameter int unsigned RECOVERY_CYC    = 6,
  parameter int unsigned REACH           = 60,
  parameter int unsigned KNOCKBACK       = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [7:0]         keycode_0,
  input  logic [7:0]         keycode_1,
  input  logic [7:0]         keycode_2,
  input  logic [7:0]         keycode_3,
  input  logic signed [10:0] XDist,
  output logic               ryu_hit,
  output logic               akuma_hit,
  output logic [7:0]         Ryu_Knockback,
  output logic [7:0]         Akuma_Knockback,
  output logic [1:0]         ryu_state,
  output logic [1:0]         akuma_state
);

  localparam int unsigned NF = 2;   // index 0 = Ryu, 1 = Akuma
  localparam int unsigned CW = 4;
  localparam int unsigned KW = 8;
  localparam int unsigned AW = 12;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_STARTUP  = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_RECOVERY = 2'd3
  } phase_e;

  phase_e          state_q [NF];
  phase_e          state_d [NF];
  logic [CW-1:0]   cnt_q   [NF];
  logic [CW-1:0]   cnt_d   [NF];
  logic [KW-1:0]   kb_q    [NF];
  logic [KW-1:0]   kb_d    [NF];
  logic [NF-1:0]   landed_q, landed_d;
  logic [NF-1:0]   hit_q, hit_d;
  logic [NF-1:0]   pressed_q, armed_q;
  logic [NF-1:0]   pressed_c, press_det_c, connect_c, struck_c;

  logic [AW-1:0]   xd_ext_c, dist_abs_c;
  logic            in_reach_c;

  function automatic logic key_down(input logic [7:0] k);
    return (keycode_0 == k) || (keycode_1 == k) ||
           (keycode_2 == k) || (keycode_3 == k);
  endfunction

  // Armed stays low after reset until the key is seen released, so a key
  // held across reset release cannot start an attack.
  always_comb begin
    pressed_c   = {key_down(AKUMA_PUNCH_KEY), key_down(RYU_PUNCH_KEY)};
    press_det_c = pressed_c & ~pressed_q & armed_q;
  end

  // 12-bit magnitude so XDist = -1024 does not wrap.
  always_comb begin
    xd_ext_c   = {XDist[10], XDist};
    dist_abs_c = xd_ext_c[AW-1] ? AW'(-xd_ext_c) : xd_ext_c;
    in_reach_c = (dist_abs_c <= AW'(REACH));
  end

  always_comb begin
    connect_c = '0;
    for (int i = 0; i < int'(NF); i++) begin
      connect_c[i] = (state_q[i] == ST_ACTIVE) && !landed_q[i] && in_reach_c;
    end
    struck_c = {connect_c[0], connect_c[1]};
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < int'(NF); i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
        kb_q[i]    <= '0;
      end
      landed_q  <= '0;
      hit_q     <= '0;
      pressed_q <= '0;
      armed_q   <= '0;
    end else begin
      for (int i = 0; i < int'(NF); i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        kb_q[i]    <= kb_d[i];
      end
      landed_q  <= landed_d;
      hit_q     <= hit_d;
      pressed_q <= pressed_c;
      armed_q   <= armed_q | ~pressed_c;
    end
  end

  // Next-state: phase sequencing; a hit during wind-up cancels the attack.
  always_comb begin
    for (int i = 0; i < int'(NF); i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        ST_IDLE: begin
          if (press_det_c[i]) begin
            state_d[i] = ST_STARTUP;
            cnt_d[i]   = CW'(STARTUP_CYC - 1);
          end
        end
        ST_STARTUP: begin
          if (struck_c[i]) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == '0) begin
            state_d[i] = ST_ACTIVE;
            cnt_d[i]   = CW'(ACTIVE_CYC - 1);
          end else begin
            cnt_d[i]   = cnt_q[i] - CW'(1);
          end
        end
        ST_ACTIVE: begin
          if (cnt_q[i] == '0) begin
            state_d[i] = ST_RECOVERY;
            cnt_d[i]   = CW'(RECOVERY_CYC - 1);
          end else begin
            cnt_d[i]   = cnt_q[i] - CW'(1);
          end
        end
        ST_RECOVERY: begin
          if (cnt_q[i] == '0) begin
            state_d[i] = ST_IDLE;
          end else begin
            cnt_d[i]   = cnt_q[i] - CW'(1);
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Outputs: landed tracking, hit pulse, knockback load/decay.
  always_comb begin
    landed_d = landed_q;
    hit_d    = struck_c;
    for (int i = 0; i < int'(NF); i++) begin
      kb_d[i] = kb_q[i];
      if (state_q[i] == ST_IDLE && press_det_c[i]) begin
        landed_d[i] = 1'b0;
      end else if (connect_c[i]) begin
        landed_d[i] = 1'b1;
      end
      if (struck_c[i]) begin
        kb_d[i] = KW'(KNOCKBACK);
      end else if (kb_q[i] != '0) begin
        kb_d[i] = kb_q[i] - KW'(1);
      end
    end
  end

  assign ryu_hit         = hit_q[0];
  assign akuma_hit       = hit_q[1];
  assign Ryu_Knockback   = kb_q[0];
  assign Akuma_Knockback = kb_q[1];
  assign ryu_state       = state_q[0];
  assign akuma_state     = state_q[1];

endmodule

// File: tb/tb_hit_resolver.sv
// Scoreboard bench for hit_resolver: a timeline-based reference model predicts
// every cycle's outputs; a monitor pops and compares them after each edge.
module tb_hit_resolver;

  localparam int S_CYC = 3;
  localparam int A_CYC = 2;
  localparam int R_CYC = 6;
  localparam int REACH = 60;
  localparam int KB    = 8;
  localparam logic [7:0] RK = 8'h09;
  localparam logic [7:0] AK = 8'h0E;

  logic               Clk = 1'b0;
  logic               Reset;
  logic [7:0]         keycode_0, keycode_1, keycode_2, keycode_3;
  logic signed [10:0] XDist;
  logic               ryu_hit, akuma_hit;
  logic [7:0]         Ryu_Knockback, Akuma_Knockback;
  logic [1:0]         ryu_state, akuma_state;

  always #5 Clk = ~Clk;

  hit_resolver #(
    .RYU_PUNCH_KEY  (RK),
    .AKUMA_PUNCH_KEY(AK),
    .STARTUP_CYC    (S_CYC),
    .ACTIVE_CYC     (A_CYC),
    .RECOVERY_CYC   (R_CYC),
    .REACH          (REACH),
    .KNOCKBACK      (KB)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .keycode_0      (keycode_0),
    .keycode_1      (keycode_1),
    .keycode_2      (keycode_2),
    .keycode_3      (keycode_3),
    .XDist          (XDist),
    .ryu_hit        (ryu_hit),
    .akuma_hit      (akuma_hit),
    .Ryu_Knockback  (Ryu_Knockback),
    .Akuma_Knockback(Akuma_Knockback),
    .ryu_state      (ryu_state),
    .akuma_state    (akuma_state)
  );

  typedef struct {
    int         cyc;
    logic       rh;
    logic       ah;
    logic [7:0] rk;
    logic [7:0] ak;
    logic [1:0] r_st;
    logic [1:0] a_st;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: an attack is just its start edge; its phase is a
  // function of elapsed edges.
  int start_e [2];
  bit landed  [2];
  int kbm     [2];
  bit hitm    [2];
  bit prevp   [2];
  bit armed   [2];
  int cyc = 0;

  function automatic int phase_at(input int st, input int n);
    int d;
    if (st < 0) return 0;
    d = n - st;
    if (d < S_CYC) return 1;
    if (d < S_CYC + A_CYC) return 2;
    if (d < S_CYC + A_CYC + R_CYC) return 3;
    return 0;
  endfunction

  function automatic bit key_down(input logic [7:0] k);
    return (keycode_0 == k) || (keycode_1 == k) || (keycode_2 == k) || (keycode_3 == k);
  endfunction

  task automatic model_edge();
    exp_t e;
    int   p    [2];
    bit   conn [2];
    bit   prs  [2];
    bit   det  [2];
    int   xv, ax, o;
    cyc++;
    if (Reset) begin
      for (int f = 0; f < 2; f++) begin
        start_e[f] = -1; landed[f] = 0; kbm[f] = 0;
        hitm[f] = 0; prevp[f] = 0; armed[f] = 0;
      end
    end else begin
      xv = int'(XDist);
      ax = (xv < 0) ? -xv : xv;
      prs[0] = key_down(RK);
      prs[1] = key_down(AK);
      for (int f = 0; f < 2; f++) begin
        p[f]    = phase_at(start_e[f], cyc - 1);
        conn[f] = (p[f] == 2) && !landed[f] && (ax <= REACH);
        det[f]  = prs[f] && !prevp[f] && armed[f];
      end
      for (int f = 0; f < 2; f++) begin
        o = 1 - f;
        hitm[o] = conn[f];
        kbm[o]  = conn[f] ? KB : ((kbm[o] > 0) ? kbm[o] - 1 : 0);
      end
      for (int f = 0; f < 2; f++) begin
        o = 1 - f;
        if (conn[f]) landed[f] = 1;
        if (p[f] == 1 && conn[o]) start_e[f] = -1;
        else if (p[f] == 0 && det[f]) begin
          start_e[f] = cyc;
          landed[f]  = 0;
        end
        prevp[f] = prs[f];
        armed[f] = armed[f] | !prs[f];
      end
    end
    e.cyc  = cyc;
    e.rh   = hitm[0];
    e.ah   = hitm[1];
    e.rk   = 8'(kbm[0]);
    e.ak   = 8'(kbm[1]);
    e.r_st = 2'(phase_at(start_e[0], cyc));
    e.a_st = 2'(phase_at(start_e[1], cyc));
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      model_edge();
      @(negedge Clk);
    end
  endtask

  task automatic keys(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] d);
    keycode_0 = a; keycode_1 = b; keycode_2 = c; keycode_3 = d;
  endtask

  // Monitor: compare DUT outputs against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        vectors++;
        if (ryu_hit !== e.rh || akuma_hit !== e.ah || Ryu_Knockback !== e.rk ||
            Akuma_Knockback !== e.ak || ryu_state !== e.r_st || akuma_state !== e.a_st) begin
          miscompares++;
          $display("FAIL outputs edge %0d: got rh=%0d ah=%0d rk=%0d ak=%0d rs=%0d as=%0d, expected rh=%0d ah=%0d rk=%0d ak=%0d rs=%0d as=%0d",
                   e.cyc, ryu_hit, akuma_hit, Ryu_Knockback, Akuma_Knockback, ryu_state, akuma_state,
                   e.rh, e.ah, e.rk, e.ak, e.r_st, e.a_st);
        end
      end
    end
  end

  initial begin
    int hold;
    int sel;
    for (int f = 0; f < 2; f++) begin
      start_e[f] = -1; landed[f] = 0; kbm[f] = 0;
      hitm[f] = 0; prevp[f] = 0; armed[f] = 0;
    end
    Reset = 1'b1;
    keys(8'h00, 8'h00, 8'h00, 8'h00);
    XDist = 11'sd40;
    tick(2);
    Reset = 1'b0;
    tick(2);

    // Ryu punch in reach
    keys(RK, 8'h00, 8'h00, 8'h00); tick(14);
    keys(8'h00, 8'h00, 8'h00, 8'h00); tick(3);

    // Just out of reach
    XDist = -11'sd61;
    keys(RK, 8'h00, 8'h00, 8'h00); tick(12);
    keys(8'h00, 8'h00, 8'h00, 8'h00); tick(3);

    // Trade
    XDist = 11'sd10;
    keys(RK, AK, 8'h00, 8'h00); tick(14);
    keys(8'h00, 8'h00, 8'h00, 8'h00); tick(3);

    // Counter-hit: Akuma first, Ryu two edges later
    keys(8'h00, AK, 8'h00, 8'h00); tick(2);
    keys(RK, AK, 8'h00, 8'h00); tick(12);
    keys(8'h00, 8'h00, 8'h00, 8'h00); tick(3);

    // Long hold in slot 3 with other slots busy, reach boundary
    XDist = 11'sd60;
    keys(8'h04, 8'h05, 8'h06, RK); tick(30);
    keys(8'h00, 8'h00, 8'h00, 8'h00); tick(3);

    // Most negative distance, then negative boundary
    XDist = -11'sd1024;
    keys(8'h00, AK, 8'h00, 8'h00); tick(12);
    keys(8'h00, 8'h00, 8'h00, 8'h00); tick(2);
    XDist = -11'sd60;
    keys(8'h00, AK, 8'h00, 8'h00); tick(12);
    keys(8'h00, 8'h00, 8'h00, 8'h00); tick(3);

    // Reset while Ryu is ACTIVE with Ryu_Knockback at 5, keys held through release
    XDist = 11'sd0;
    keys(8'h00, AK, 8'h00, 8'h00); tick(4);
    keys(RK, AK, 8'h00, 8'h00); tick(4);
    Reset = 1'b1; tick(1);
    Reset = 1'b0; tick(12);
    keys(8'h00, 8'h00, 8'h00, 8'h00); tick(2);
    keys(RK, 8'h00, 8'h00, 8'h00); tick(12);
    keys(8'h00, 8'h00, 8'h00, 8'h00); tick(3);

    // Randomized traffic
    for (int it = 0; it < 600; it++) begin
      logic [7:0] kv [4];
      for (int s = 0; s < 4; s++) begin
        sel = int'($urandom_range(0, 9));
        if (sel <= 4)      kv[s] = 8'h00;
        else if (sel == 5) kv[s] = RK;
        else if (sel == 6) kv[s] = AK;
        else               kv[s] = 8'($urandom);
      end
      keys(kv[0], kv[1], kv[2], kv[3]);
      sel = int'($urandom_range(0, 9));
      case (sel)
        0: XDist = -11'sd1024;
        1: XDist = -11'sd61;
        2: XDist = -11'sd60;
        3: XDist = 11'sd60;
        4: XDist = 11'sd61;
        5: XDist = 11'sd1023;
        6: XDist = 11'sd0;
        default: XDist = 11'($urandom);
      endcase
      Reset = ($urandom_range(0, 99) == 0);
      hold  = int'($urandom_range(1, 8));
      tick(hold);
      Reset = 1'b0;
    end

    keys(8'h00, 8'h00, 8'h00, 8'h00);
    tick(3);
    repeat (2) @(negedge Clk);
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
